// File: rtl/keypad_pkg.sv
// Shared keypad definitions: column strobes, key codes, key-to-matrix mapping and
// the emulator FSM state type used by both the emulator and the scanner side.
package keypad_pkg;

  localparam logic [3:0] ROW_NONE = 4'b1111;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_E = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } kp_state_t;

  typedef struct packed {
    logic [1:0] col;
    logic [3:0] row_mask;
    logic       mapped;
  } key_loc_t;

  // Active-low one-hot strobe the scanner drives while sampling column idx.
  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic key_loc_t key_to_loc(input logic [3:0] code);
    key_loc_t loc;
    loc = '{col: 2'd0, row_mask: ROW_NONE, mapped: 1'b0};
    case (code)
      4'h1:  loc = '{col: 2'd0, row_mask: 4'b1110, mapped: 1'b1};
      4'h4:  loc = '{col: 2'd0, row_mask: 4'b1101, mapped: 1'b1};
      4'h7:  loc = '{col: 2'd0, row_mask: 4'b1011, mapped: 1'b1};
      4'h0:  loc = '{col: 2'd0, row_mask: 4'b0111, mapped: 1'b1};
      4'h2:  loc = '{col: 2'd1, row_mask: 4'b1110, mapped: 1'b1};
      4'h5:  loc = '{col: 2'd1, row_mask: 4'b1101, mapped: 1'b1};
      4'h8:  loc = '{col: 2'd1, row_mask: 4'b1011, mapped: 1'b1};
      4'h3:  loc = '{col: 2'd2, row_mask: 4'b1110, mapped: 1'b1};
      4'h6:  loc = '{col: 2'd2, row_mask: 4'b1101, mapped: 1'b1};
      4'h9:  loc = '{col: 2'd2, row_mask: 4'b1011, mapped: 1'b1};
      KEY_E: loc = '{col: 2'd2, row_mask: 4'b0111, mapped: 1'b1};
      KEY_A: loc = '{col: 2'd3, row_mask: 4'b1110, mapped: 1'b1};
      KEY_C: loc = '{col: 2'd3, row_mask: 4'b1011, mapped: 1'b1};
      default: loc = '{col: 2'd0, row_mask: ROW_NONE, mapped: 1'b0};
    endcase
    return loc;
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Synchronous request FIFO holding {col, row_mask} per queued key.
// Full/empty come only from registered pointers, so a pop never frees a slot same-cycle.
module keypad_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count   = r_wptr - r_rptr;
  assign o_full    = (w_count == FULL_CNT);
  assign o_empty   = (w_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates a 4x4 keypad on a row/column scanner: queues key requests, presses each
// for a minimum hold time (until seen at least once), then releases for a fixed gap.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 16,
  parameter int RELEASE_CYCLES = 16,
  parameter int DEPTH          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] column,
  output logic [3:0] row,
  input  logic [3:0] key_digit,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       key_err,
  output logic       key_done,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshake: a request transfers on a rising clk edge where key_valid & key_ready
  // are both high; key_ready depends only on registered FIFO state, never on key_valid.
  localparam int CNT_MAX = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

  kp_state_t        r_state;
  kp_state_t        w_state_n;
  logic [1:0]       r_cur_col;
  logic [3:0]       r_cur_mask;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_rel_cnt;
  logic             r_seen;
  logic             r_err;
  logic             r_done;

  key_loc_t   w_loc;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [5:0] w_head;
  logic       w_match;

  assign w_loc    = key_to_loc(key_digit);
  assign w_accept = key_valid & key_ready;
  assign w_push   = w_accept & w_loc.mapped;
  assign w_match  = (column == col_strobe(r_cur_col));

  keypad_key_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(6)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_data ({w_loc.col, w_loc.row_mask}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_n = ST_PRESS;
        end
      end
      ST_PRESS: begin
        // Never release a key the scanner has not observed at least once.
        if ((r_hold_cnt >= HOLD_LAST) && (r_seen || w_match)) w_state_n = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (r_rel_cnt >= REL_LAST) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cur_col  <= 2'd0;
      r_cur_mask <= ROW_NONE;
      r_hold_cnt <= '0;
      r_rel_cnt  <= '0;
      r_seen     <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_err   <= w_accept & ~w_loc.mapped;
      r_done  <= (r_state == ST_RELEASE) && (w_state_n == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cur_col  <= w_head[5:4];
            r_cur_mask <= w_head[3:0];
            r_hold_cnt <= '0;
            r_seen     <= 1'b0;
          end
        end
        ST_PRESS: begin
          if (r_hold_cnt != CNT_SAT) r_hold_cnt <= r_hold_cnt + 1'b1;
          if (w_match) r_seen <= 1'b1;
          if (w_state_n == ST_RELEASE) r_rel_cnt <= '0;
        end
        ST_RELEASE: begin
          if (r_rel_cnt != CNT_SAT) r_rel_cnt <= r_rel_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Same-cycle row response; a non-one-hot column can never equal a strobe.
  assign row       = ((r_state == ST_PRESS) && w_match) ? r_cur_mask : ROW_NONE;
  assign key_ready = ~w_full;
  assign key_err   = r_err;
  assign key_done  = r_done;
  assign busy      = ~w_empty | (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a column scanner that stalls on a pressed row reports
// decoded keys; a monitor checks them in order against the queued expectations.
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int HOLD = 16;
  localparam int REL  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] column;
  logic [3:0] row;
  logic [3:0] key_digit;
  logic       key_valid;
  logic       key_ready;
  logic       key_err;
  logic       key_done;
  logic       busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD),
    .RELEASE_CYCLES(REL),
    .DEPTH         (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .column   (column),
    .row      (row),
    .key_digit(key_digit),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_err  (key_err),
    .key_done (key_done),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];
  int exp_err   = 0;
  int err_seen  = 0;
  int done_seen = 0;

  // scanner state and controls
  logic [1:0] sc_idx;
  logic [1:0] sc_idx_n;
  logic       sc_latch;
  logic       sc_rep;
  logic [3:0] sc_dig;
  logic       scan_valid;
  logic [3:0] scan_digit;
  logic       scan_freeze;
  logic       force_en;
  logic [3:0] force_col;

  // test bookkeeping
  int cyc, press, vis, bad, last_press, done_at;
  logic [3:0] burst[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] strobe(input logic [1:0] i);
    case (i)
      2'd0: return 4'b1110;
      2'd1: return 4'b1101;
      2'd2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Physical keypad layout as seen by the scanner: (row mask, column index) -> key.
  function automatic logic [3:0] decode(input logic [1:0] c, input logic [3:0] r);
    case ({r, c})
      {4'b1110, 2'd0}: return 4'h1;
      {4'b1101, 2'd0}: return 4'h4;
      {4'b1011, 2'd0}: return 4'h7;
      {4'b0111, 2'd0}: return 4'h0;
      {4'b1110, 2'd1}: return 4'h2;
      {4'b1101, 2'd1}: return 4'h5;
      {4'b1011, 2'd1}: return 4'h8;
      {4'b1110, 2'd2}: return 4'h3;
      {4'b1101, 2'd2}: return 4'h6;
      {4'b1011, 2'd2}: return 4'h9;
      {4'b0111, 2'd2}: return 4'hE;
      {4'b1110, 2'd3}: return 4'hA;
      {4'b1011, 2'd3}: return 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  // Scanner: samples row mid-cycle, stalls on a press, reports each press once.
  initial begin
    sc_idx     = 2'd0;
    sc_latch   = 1'b0;
    scan_valid = 1'b0;
    scan_digit = 4'h0;
    column     = strobe(2'd0);
    forever begin
      @(negedge clk);
      sc_rep = 1'b0;
      sc_dig = 4'h0;
      if (!force_en && (row !== 4'b1111) && !sc_latch) begin
        sc_rep = 1'b1;
        sc_dig = decode(sc_idx, row);
      end
      if (scan_freeze) sc_idx_n = 2'd0;
      else if (row !== 4'b1111) sc_idx_n = sc_idx;
      else sc_idx_n = sc_idx + 2'd1;
      @(posedge clk);
      #1;
      sc_latch   = (row !== 4'b1111);
      sc_idx     = sc_idx_n;
      scan_valid = sc_rep;
      scan_digit = sc_dig;
      column     = force_en ? force_col : strobe(sc_idx_n);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (key_err)  err_seen++;
      if (key_done) done_seen++;
      if (scan_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL key_seq: got key %0h expected none", scan_digit);
        end else begin
          check("key_seq", scan_digit, exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic push_key(input logic [3:0] d, input logic ok);
    int t;
    t = 0;
    key_digit = d;
    key_valid = 1'b1;
    while (!key_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!key_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: key %0h key_ready=%0b required 1", d, key_ready);
      key_valid = 1'b0;
    end else begin
      if (ok) exp_q.push_back(d);
      else exp_err++;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    key_valid   = 1'b0;
    key_digit   = 4'h0;
    scan_freeze = 1'b0;
    force_en    = 1'b0;
    force_col   = 4'b1111;
    burst = '{4'h1, 4'h2, 4'h3, KEY_A, KEY_C, KEY_E, 4'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_row", row, 4'b1111);
    check("rst_ready", key_ready, 1'b1);
    check("rst_err", key_err, 1'b0);
    check("rst_done", key_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single key 5
    push_key(4'h5, 1'b1);
    cyc = 0; press = 0; vis = 0; bad = 0; last_press = -1; done_at = -1;
    while (done_at < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dbg_state == ST_PRESS) begin
        press++;
        last_press = cyc;
        if (column === 4'b1101 && row !== 4'b1101) bad++;
      end
      if (row !== 4'b1111 && (row !== 4'b1101 || column !== 4'b1101)) bad++;
      if (row !== 4'b1111) vis++;
      if (key_done) done_at = cyc;
    end
    check("k5_done_seen", done_at >= 0, 1'b1);
    check("k5_press_cycles", press, HOLD);
    check("k5_visible", vis >= 1, 1'b1);
    check("k5_bad_row", bad, 0);
    check("k5_done_gap", done_at - last_press, REL + 1);

    // Burst of seven keys through a four-entry FIFO
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      push_key(burst[i], 1'b1);
      if (i == 4) check("burst_full_ready", key_ready, 1'b0);
    end
    cyc = 0;
    while (busy && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check("burst_drained", busy, 1'b0);
    check("burst_all_seen", exp_q.size(), 0);

    // Unmapped codes
    @(posedge clk);
    #1;
    push_key(4'hB, 1'b0);
    check("errB_pulse", key_err, 1'b1);
    check("errB_busy", busy, 1'b0);
    check("errB_row", row, 4'b1111);
    push_key(4'hD, 1'b0);
    check("errD_pulse", key_err, 1'b1);
    check("errD_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    check("err_pulse_end", key_err, 1'b0);
    check("err_row", row, 4'b1111);

    // Scanner frozen on column 0 while key 9 (column 2) is pending
    @(negedge clk);
    #1 scan_freeze = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_key(4'h9, 1'b1);
    vis = 0;
    repeat (30) begin
      @(negedge clk);
      if (row !== 4'b1111) vis++;
    end
    check("freeze_holding", dbg_state, ST_PRESS);
    check("freeze_no_row", vis, 0);
    #1 scan_freeze = 1'b0;
    cyc = 0; vis = 0; bad = 0; done_at = -1;
    while (done_at < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (row !== 4'b1111) begin
        vis++;
        if (row !== 4'b1011 || column !== 4'b1011) bad++;
      end
      if (key_done) done_at = cyc;
    end
    check("unfreeze_done", done_at >= 0, 1'b1);
    check("unfreeze_one_match", vis, 1);
    check("unfreeze_bad_row", bad, 0);

    // Illegal columns during PRESS, then reset mid-press
    @(negedge clk);
    #1;
    force_col = 4'b1100;
    force_en  = 1'b1;
    @(posedge clk);
    #1;
    push_key(4'h7, 1'b1);
    push_key(4'h4, 1'b1);
    cyc = 0;
    while (dbg_state != ST_PRESS && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("illegal_1100_row", row, 4'b1111);
    #1 force_col = 4'b1111;
    @(negedge clk);
    check("illegal_1111_row", row, 4'b1111);
    #1 force_col = 4'b1110;
    @(negedge clk);
    check("k7_row", row, 4'b1011);
    check("k7_state", dbg_state, ST_PRESS);
    check("k7_fifo_pending", busy, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_row", row, 4'b1111);
    check("midrst_ready", key_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1 force_en = 1'b0;
    vis = 0;
    repeat (40) begin
      @(negedge clk);
      if (row !== 4'b1111 || busy) vis++;
    end
    check("postrst_quiet", vis, 0);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_err_count", err_seen, exp_err);
    check("final_done_count", done_seen, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
